// File: rtl/core_run_controller.sv
// core_run_controller: launches a set of cores, tracks their end-of-operation flags and reports done or timeout.
module core_run_controller #(
  parameter int core_count = 4,
  parameter int cnt_width  = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [core_count-1:0] core_enable,
  input  logic [core_count-1:0] endop_signal,
  input  logic [cnt_width-1:0]  timeout_limit,
  output logic [core_count-1:0] core_start,
  output logic                  busy,
  output logic                  all_done,
  output logic                  timeout,
  output logic [core_count-1:0] done_mask,
  output logic [cnt_width-1:0]  cycle_count
);
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_RUN, S_DONE, S_TIMEOUT} state_t;
  state_t state, state_nx;
  logic [core_count-1:0] run_mask, hits;
  logic [cnt_width:0] cnt_inc;
  logic accept, complete, expired;
  assign hits     = done_mask | (endop_signal & run_mask);
  assign complete = hits == run_mask;
  // one extra bit so the limit compare stays correct when the counter is saturated
  assign cnt_inc  = {1'b0, cycle_count} + {{cnt_width{1'b0}}, 1'b1};
  assign expired  = |timeout_limit && cnt_inc >= {1'b0, timeout_limit};
  assign accept   = start && |core_enable &&
                    (state == S_IDLE || state == S_DONE || state == S_TIMEOUT);
  always_ff @(posedge clk)
    if (!reset) state <= S_IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      S_LAUNCH: state_nx = S_RUN;
      S_RUN:    state_nx = complete ? S_DONE : expired ? S_TIMEOUT : S_RUN;
      default:  state_nx = accept ? S_LAUNCH : state;
    endcase
  end
  always_comb begin
    core_start = state == S_LAUNCH ? run_mask : '0;
    busy       = state == S_LAUNCH || state == S_RUN;
    all_done   = state == S_DONE;
    timeout    = state == S_TIMEOUT;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      run_mask    <= '0;
      done_mask   <= '0;
      cycle_count <= '0;
    end else if (accept) begin
      run_mask    <= core_enable;
      done_mask   <= '0;
      cycle_count <= '0;
    end else if (state == S_RUN) begin
      done_mask   <= hits;
      cycle_count <= cnt_inc[cnt_width] ? cycle_count : cnt_inc[cnt_width-1:0];
    end
endmodule

// File: tb/tb_core_run_controller.sv
// tb_core_run_controller: directed scenarios plus random traffic against a behavioural run model.
module tb_core_run_controller;
  logic clk = 0, reset = 0, start = 0;
  logic [3:0] core_enable = 0, endop_signal = 0;
  logic [15:0] timeout_limit = 0;
  logic [3:0] core_start, done_mask;
  logic busy, all_done, timeout;
  logic [15:0] cycle_count;
  int errors = 0, checks = 0;
  int phase = 0;
  logic [3:0] m_mask = 0, m_dm = 0;
  int m_cnt = 0;
  int launches;

  core_run_controller dut (
    .clk(clk), .reset(reset), .start(start), .core_enable(core_enable),
    .endop_signal(endop_signal), .timeout_limit(timeout_limit),
    .core_start(core_start), .busy(busy), .all_done(all_done), .timeout(timeout),
    .done_mask(done_mask), .cycle_count(cycle_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // phase: 0 idle, 1 launching, 2 running, 3 finished, 4 timed out
  task automatic model_step();
    logic [3:0] seen;
    int old;
    if (!reset) begin
      phase = 0; m_mask = 0; m_dm = 0; m_cnt = 0;
    end else if (phase == 1) phase = 2;
    else if (phase == 2) begin
      old = m_cnt;
      seen = m_dm | (endop_signal & m_mask);
      m_dm = seen;
      m_cnt = old == 65535 ? old : old + 1;
      if (seen == m_mask) phase = 3;
      else if (timeout_limit != 0 && old + 1 >= int'(timeout_limit)) phase = 4;
    end else if (start && core_enable != 0) begin
      phase = 1; m_mask = core_enable; m_dm = 0; m_cnt = 0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("core_start", 32'(core_start), 32'(phase == 1 ? m_mask : 4'b0));
    check("busy", 32'(busy), 32'(phase == 1 || phase == 2));
    check("all_done", 32'(all_done), 32'(phase == 3));
    check("timeout", 32'(timeout), 32'(phase == 4));
    check("done_mask", 32'(done_mask), 32'(m_dm));
    check("cycle_count", 32'(cycle_count), 32'(m_cnt));
  endtask

  task automatic launch(input logic [3:0] en, input logic [15:0] lim);
    start = 1; core_enable = en; timeout_limit = lim; endop_signal = 0;
    step();
    start = 0; core_enable = 0;
    step();
  endtask

  initial begin
    reset = 0;
    step(); step();
    check("reset_idle", {busy, all_done, timeout, core_start}, 0);
    reset = 1;
    // all four cores, endops on RUN cycles 2,3,3,6
    start = 1; core_enable = 4'b1111; timeout_limit = 0;
    step();
    check("launch_pulse", 32'(core_start), 32'hf);
    start = 0; endop_signal = 4'b1111;
    step();
    check("launch_ignores_endop", 32'(done_mask), 0);
    for (int k = 1; k <= 6; k++) begin
      endop_signal = k == 2 ? 4'b0001 : k == 3 ? 4'b0110 : k == 6 ? 4'b1000 : 4'b0000;
      step();
      if (k == 5) check("not_done_yet", 32'(all_done), 0);
    end
    endop_signal = 0;
    check("all_done", 32'(all_done), 1);
    check("final_mask", 32'(done_mask), 32'hf);
    check("final_count", 32'(cycle_count), 6);
    step(); step();
    check("done_frozen_cnt", 32'(cycle_count), 6);
    // partial enable, disabled bits held high
    launch(4'b0101, 0);
    endop_signal = 4'b1010; step(); step();
    check("ignore_disabled", 32'(done_mask), 0);
    endop_signal = 4'b1011; step();
    endop_signal = 4'b1010; step();
    check("bit0_only", 32'(done_mask), 32'h1);
    check("still_busy", 32'(busy), 1);
    endop_signal = 4'b0100; step();
    endop_signal = 0;
    check("done_after_bit2", 32'(all_done), 1);
    // timeout at limit 5
    launch(4'b1111, 5);
    endop_signal = 4'b0001; step();
    endop_signal = 0;
    for (int k = 0; k < 4; k++) step();
    check("timeout_hit", 32'(timeout), 1);
    check("timeout_cnt", 32'(cycle_count), 5);
    check("timeout_mask", 32'(done_mask), 32'h1);
    check("timeout_busy", 32'(busy), 0);
    start = 1; core_enable = 4'b0011; step();
    start = 0;
    check("restart_clears_timeout", 32'(timeout), 0);
    check("restart_cnt", 32'(cycle_count), 0);
    step();
    // completion beats timeout on the same edge
    endop_signal = 4'b0011; step(); endop_signal = 0;
    launch(4'b0011, 3);
    endop_signal = 4'b0001; step();
    endop_signal = 0; step();
    endop_signal = 4'b0010; step();
    endop_signal = 0;
    check("completion_wins", 32'(all_done), 1);
    check("completion_cnt", 32'(cycle_count), 3);
    // reset mid-run
    launch(4'b1111, 0);
    endop_signal = 4'b0011; step();
    endop_signal = 4'b1100; reset = 0; start = 1; core_enable = 4'b1111; step();
    check("reset_mid_run", {busy, all_done, timeout, core_start, done_mask, cycle_count}, 0);
    reset = 1; start = 1; core_enable = 0; endop_signal = 0; step(); step();
    check("zero_enable_ignored", 32'(busy), 0);
    // start held high: one launch per pass through DONE
    launches = 0;
    core_enable = 4'b0001; endop_signal = 4'b0001;
    for (int k = 0; k < 12; k++) begin
      step();
      if (core_start != 0) launches++;
    end
    check("held_start_launches", launches, 4);
    start = 0; endop_signal = 0; core_enable = 0;
    step(); step();
    // random traffic
    for (int k = 0; k < 3000; k++) begin
      reset = $urandom_range(0, 63) != 0;
      start = $urandom_range(0, 3) == 0;
      core_enable = 4'($urandom);
      endop_signal = $urandom_range(0, 2) == 0 ? 4'($urandom) : 4'b0;
      if ($urandom_range(0, 15) == 0) timeout_limit = 16'($urandom_range(0, 10));
      step();
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/core_run_controller.md
CORE_RUN_CONTROLLER -- requirements
Module: core_run_controller

Interface
REQ-001 SHALL have parameter core_count, default 4: number of cores supervised.
REQ-002 SHALL have parameter cnt_width, default 16: width of the cycle counter and timeout limit.
REQ-003 SHALL have port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1: synchronous, active-low reset; takes effect on the clk rising edge while 0.
REQ-005 SHALL have port start  input  1: run request, sampled only in IDLE, DONE and TIMEOUT.
REQ-006 SHALL have port core_enable  input  core_count: set of cores taking part in the run, latched at accepted start.
REQ-007 SHALL have port endop_signal  input  core_count: per-core end-of-operation indication, bit i from core i.
REQ-008 SHALL have port timeout_limit  input  cnt_width: maximum RUN cycles; 0 disables the timeout.
REQ-009 SHALL have port core_start  output  core_count: one-cycle start pulse to each latched-enabled core.
REQ-010 SHALL have port busy  output  1: high in LAUNCH and RUN.
REQ-011 SHALL have port all_done  output  1: high in DONE.
REQ-012 SHALL have port timeout  output  1: high in TIMEOUT.
REQ-013 SHALL have port done_mask  output  core_count: sticky record of which enabled cores have signalled endop.
REQ-014 SHALL have port cycle_count  output  cnt_width: RUN cycles elapsed in the current or last run.

Function
REQ-015 SHALL implement the FSM states IDLE, LAUNCH, RUN, DONE and TIMEOUT.
REQ-016 IDLE, DONE, TIMEOUT: start=1 with core_enable!=0 -> LAUNCH on the next edge; the same edge latches core_enable into run_mask and clears done_mask and cycle_count to 0.
REQ-017 start=1 with core_enable==0 SHALL be ignored; the state and all outputs hold.
REQ-018 LAUNCH SHALL last exactly one cycle, with core_start=run_mask for that cycle only, and SHALL go to RUN unconditionally.
REQ-019 core_start SHALL be 0 in every state except LAUNCH.
REQ-020 RUN: on each edge, done_mask <= done_mask | (endop_signal & run_mask), and cycle_count increments by 1, saturating at all-ones.
REQ-021 RUN: when (done_mask | (endop_signal & run_mask)) == run_mask, the same edge SHALL go to DONE; all_done is high from the next cycle.
REQ-022 RUN: when timeout_limit!=0, completion is not met and cycle_count+1 >= timeout_limit, the edge SHALL go to TIMEOUT.
REQ-023 Completion and timeout on the same edge: completion wins and the next state is DONE.
REQ-024 endop_signal SHALL be ignored outside RUN, including during the LAUNCH cycle, and for bits outside run_mask.
REQ-025 start, core_enable and timeout_limit changes during LAUNCH/RUN SHALL have no effect on the run in progress; timeout_limit is compared live each RUN cycle.
REQ-026 DONE and TIMEOUT SHALL hold done_mask and cycle_count frozen until the next accepted start.
REQ-027 A new start from DONE or TIMEOUT SHALL deassert all_done/timeout on the edge entering LAUNCH.
REQ-028 endop_signal bits are levels or pulses: any single RUN-cycle assertion is captured permanently.

Reset
REQ-029 reset=0 at a rising edge SHALL force IDLE and set core_start, busy, all_done, timeout, done_mask, cycle_count and run_mask to 0, from any state including mid-RUN.
REQ-030 reset SHALL take priority over start and endop_signal on the same edge.
REQ-031 After reset is released, the first start is accepted on the next rising edge.

Verification
REQ-032 core_count=4; core_enable=4'b1111, start for 1 cycle; endop bits 0..3 pulsed on RUN cycles 2,3,3,6 -> core_start=1111 for one cycle; all_done rises after the bit-3 edge; done_mask=1111; cycle_count=6.
REQ-033 core_enable=4'b0101; endop=4'b1010 held high, then bit0 then bit2 pulsed -> done_mask ignores bits 1 and 3; DONE only after bit 2; core_start=0101.
REQ-034 timeout_limit=5, core_enable=1111, only bit0 pulsed -> TIMEOUT after 5 RUN cycles; cycle_count=5, done_mask=0001, busy=0; a subsequent start clears timeout and restarts.
REQ-035 timeout_limit=3 with the final endop arriving on RUN cycle 3 -> DONE, not TIMEOUT; cycle_count=3.
REQ-036 Apply reset=0 during RUN with done_mask=0011 -> next cycle IDLE, all outputs 0; start with core_enable=0 -> stays IDLE.
REQ-037 start held high continuously through DONE -> exactly one LAUNCH per accepted start from DONE; no LAUNCH while busy.
